// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the UART receive buffer slice.
//   UART_DATA_W           default byte width of the receive path
//   UART_FIFO_DEPTH_LOG2  default log2 of the receive FIFO depth
//   fifo_op_e             per-cycle FIFO operation, encoded as {push, pop}
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;

  // Bit 1 is push and bit 0 is pop.
  // A value can therefore be built directly from the two strobes.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Storage for the receive FIFO: a WIDTH x 2**ADDR_W register array with one
// synchronous write port and one asynchronous read port. It has no reset;
// validity of each entry is tracked entirely by the pointers in the parent.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  contents of mem[raddr], combinational
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH  = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer placed directly after the UART receiver. Each byte strobed by
// the receiver is queued in a first-word-fall-through FIFO and offered to the
// consumer over a valid/ready handshake. When a byte arrives with no room, it
// is dropped and a sticky overrun flag is raised.
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   i_data     in   received byte, sampled when i_rcv=1
//   i_rcv      in   one-cycle push strobe from the receiver
//   o_data     out  head-of-queue byte, 0 while empty
//   o_valid    out  queue non-empty
//   i_ready    in   consumer takes o_data this cycle
//   o_count    out  number of stored entries, 0..2**DEPTH_LOG2
//   o_full     out  queue holds 2**DEPTH_LOG2 entries
//   o_empty    out  queue holds no entries
//   o_overrun  out  sticky: a byte was dropped since the last clear
//   i_clr_ovr  in   one-cycle pulse that clears o_overrun
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH      = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_rcv,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overrun,
  input  logic                  i_clr_ovr
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             overrun;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [WIDTH-1:0] rdata;
  fifo_op_e         op;

  // The pointers carry one extra wrap bit.
  // When the address bits are equal, the wrap bit tells full apart from empty.
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign empty = (wr_ptr == rd_ptr);

  // A pop in the same cycle frees the slot that a push into a full queue needs.
  // The push is therefore accepted.
  // There is no bypass when the queue is empty: pop requires a non-empty queue.
  assign pop  = i_ready & ~empty;
  assign push = i_rcv & (~full | pop);
  assign drop = i_rcv & full & ~pop;
  assign op   = fifo_op_e'({push, pop});

  uart_fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (i_data),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // The count is kept as its own register and is not derived from the pointers.
  // This gives the consumer a glitch-free level output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + PTR_W'(1);
        OP_POP:  count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

  // If a drop and a clear occur in the same cycle, the drop wins.
  // This prevents a lost byte from going unreported.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  assign o_data    = empty ? '0 : rdata;
  assign o_valid   = ~empty;
  assign o_empty   = empty;
  assign o_full    = full;
  assign o_count   = count;
  assign o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. The driver keeps an abstract model of the queue:
// an occupancy number, an overrun bit, and a queue of expected bytes. Each
// byte the model accepts goes onto the scoreboard. A monitor running on the
// falling edge checks the status outputs against the model. Whenever the DUT
// offers a byte that the consumer takes, the monitor pops the scoreboard and
// compares the byte against it.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic              clk;
  logic              rstn;
  logic [WIDTH-1:0]  i_data;
  logic              i_rcv;
  logic [WIDTH-1:0]  o_data;
  logic              o_valid;
  logic              i_ready;
  logic [DEPTH_LOG2:0] o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_overrun;
  logic              i_clr_ovr;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               mdl_count = 0;
  bit               mdl_ovr   = 1'b0;
  int               mdl_accepted = 0;

  uart_rx_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_data    (i_data),
    .i_rcv     (i_rcv),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_overrun (o_overrun),
    .i_clr_ovr (i_clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Applies one cycle of stimulus and lets the clock edge occur.
  // The model is then advanced from the queue rules, independently of the DUT.
  task automatic apply_stimulus(input bit rcv, input logic [WIDTH-1:0] data,
                                input bit ready, input bit clr);
    bit model_pop;
    bit model_accept;
    i_rcv     = rcv;
    i_data    = data;
    i_ready   = ready;
    i_clr_ovr = clr;
    @(posedge clk);
    #2;
    if (rstn) begin
      model_pop    = ready && (mdl_count > 0);
      model_accept = rcv && ((mdl_count < DEPTH) || model_pop);
      if (model_accept) begin
        exp_q.push_back(data);
        mdl_accepted++;
      end
      mdl_count = mdl_count + int'(model_accept) - int'(model_pop);
      if (rcv && !model_accept) mdl_ovr = 1'b1;
      else if (clr)             mdl_ovr = 1'b0;
    end
    i_rcv     = 1'b0;
    i_ready   = 1'b0;
    i_clr_ovr = 1'b0;
  endtask

  task automatic do_reset();
    i_rcv     = 1'b0;
    i_ready   = 1'b0;
    i_clr_ovr = 1'b0;
    rstn      = 1'b0;
    mdl_count = 0;
    mdl_ovr   = 1'b0;
    exp_q.delete();
    #1;
    check_output("rst_count",   int'(o_count),   0);
    check_output("rst_valid",   int'(o_valid),   0);
    check_output("rst_empty",   int'(o_empty),   1);
    check_output("rst_overrun", int'(o_overrun), 0);
    check_output("rst_data",    int'(o_data),    0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, base + WIDTH'(k), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
  endtask

  // The monitor samples in mid-cycle.
  // The status outputs must match the model state left by the last edge.
  // A handshake visible now completes at the next edge, so the head byte is
  // checked against the scoreboard at this point.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_byte;
    check_output("count",   int'(o_count),   mdl_count);
    check_output("valid",   int'(o_valid),   int'(mdl_count > 0));
    check_output("empty",   int'(o_empty),   int'(mdl_count == 0));
    check_output("full",    int'(o_full),    int'(mdl_count == DEPTH));
    check_output("overrun", int'(o_overrun), int'(mdl_ovr));
    if (!o_valid) check_output("idle_data", int'(o_data), 0);
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check_output("sb_underflow", int'(o_data), -1);
      end else begin
        exp_byte = exp_q.pop_front();
        check_output("head_data", int'(o_data), int'(exp_byte));
      end
    end
  end

  initial begin
    int pushed_start;
    int cycles;
    rstn      = 1'b0;
    i_rcv     = 1'b0;
    i_data    = '0;
    i_ready   = 1'b0;
    i_clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;

    // Reset mid-stream with the queue full and the overrun flag set
    fill(8'hC0, DEPTH + 1);
    check_output("pre_rst_ovr", int'(o_overrun), 1);
    do_reset();

    // Single byte: it appears after one edge, then is consumed
    apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    check_output("t2_valid", int'(o_valid), 1);
    check_output("t2_data",  int'(o_data),  'hA5);
    check_output("t2_count", int'(o_count), 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("t2_valid_after", int'(o_valid), 0);
    check_output("t2_count_after", int'(o_count), 0);

    // Fill, drop one byte, then drain in order
    fill(8'h00, DEPTH);
    check_output("t3_full",  int'(o_full),  1);
    check_output("t3_count", int'(o_count), DEPTH);
    apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
    check_output("t3_overrun", int'(o_overrun), 1);
    check_output("t3_count_drop", int'(o_count), DEPTH);
    drain(DEPTH);
    check_output("t3_drained", int'(o_count), 0);

    // Push and pop together while full
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("t4_clr", int'(o_overrun), 0);
    fill(8'h20, DEPTH);
    apply_stimulus(1'b1, 8'h77, 1'b1, 1'b0);
    check_output("t4_count",   int'(o_count),   DEPTH);
    check_output("t4_overrun", int'(o_overrun), 0);
    drain(DEPTH);
    check_output("t4_empty", int'(o_empty), 1);

    // Random traffic: 40 accepted bytes with random gaps and consumer stalls
    pushed_start = mdl_accepted;
    cycles = 0;
    while (((mdl_accepted - pushed_start) < 40 || mdl_count > 0) && cycles < 2000) begin
      apply_stimulus(((mdl_accepted - pushed_start) < 40) && ($urandom_range(0, 1) == 1),
                     WIDTH'($urandom), ($urandom_range(0, 2) != 0), 1'b0);
      cycles++;
    end
    check_output("t5_complete", int'(cycles < 2000), 1);

    // A drop wins over a simultaneous clear; a clear on its own then works
    fill(8'h40, DEPTH);
    apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    check_output("t6_drop_wins", int'(o_overrun), 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("t6_clear", int'(o_overrun), 0);
    drain(DEPTH);

    check_output("sb_leftover", exp_q.size(), 0);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
